// File: rtl/rv32m_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32m_pkg
// Purpose  : Shared definitions for the RV32M multiply/divide unit: funct3
//            decodes, the M-extension opcode/funct7 and the FSM encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rv32m_pkg;

    localparam logic [6:0] OPCODE_OP   = 7'b0110011;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_core
// Purpose  : Per-iteration datapath. One shift-add multiply step or one
//            restoring-divide step per cycle on unsigned magnitudes.
// Ports    : clk, rst (async active-low)
//            load   - initialise with a_mag / b_mag, counter = 0
//            clear  - clear the counter (kill)
//            step   - perform one iteration
//            is_div - 1: divide step, 0: multiply step
//            hi/lo  - {hi,lo} = product; hi = remainder, lo = quotient
//            last   - current step is the final iteration
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            last
);

    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_b;
    logic [CNT_W-1:0] r_cnt;

    logic [XLEN:0]    w_sum;
    logic [XLEN:0]    w_shift;
    logic             w_ge;
    logic [XLEN-1:0]  w_sub;
    logic [XLEN-1:0]  w_hi_next;
    logic [XLEN-1:0]  w_lo_next;

    // Multiply: lo holds the multiplier, shifted out LSB-first while the
    // partial product enters from the top; {hi,lo} ends as the full product.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

    // Divide: lo holds the dividend, shifted MSB-first into the remainder.
    // The shifted remainder is at most XLEN+1 bits; once the trial subtract
    // succeeds the difference is below the divisor, so XLEN bits suffice.
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_sub   = w_shift[XLEN-1:0] - r_b;

    always_comb begin
        w_hi_next = w_sum[XLEN:1];
        w_lo_next = {w_sum[0], r_lo[XLEN-1:1]};
        if (is_div) begin
            w_hi_next = w_ge ? w_sub : w_shift[XLEN-1:0];
            w_lo_next = {r_lo[XLEN-2:0], w_ge};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (load) begin
            r_hi  <= '0;
            r_lo  <= a_mag;
            r_b   <= b_mag;
            r_cnt <= '0;
        end else if (step) begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign last = (r_cnt == CNT_W'(XLEN - 1));

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit for the EX stage. Handles
//            operand signs, divide special cases and the control FSM; the
//            iteration itself lives in muldiv_core.
// Ports    : clk, rst (async active-low), start, funct3, op_a, op_b, rd_in,
//            flush -> stall_req, done, result, rd_out, busy
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);

    state_t          r_state;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic            r_sign_a;
    logic            r_sign_b;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd_out;
    logic            r_done;

    logic            w_signed_a;
    logic            w_signed_b;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_accept;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;
    logic            w_last;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_fix_res;

    assign w_signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                        (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign w_signed_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                        (funct3 == F3_REM);
    assign w_sign_a   = w_signed_a & op_a[XLEN-1];
    assign w_sign_b   = w_signed_b & op_b[XLEN-1];
    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign w_mag_a    = w_sign_a ? -op_a : op_a;
    assign w_mag_b    = w_sign_b ? -op_b : op_b;

    // funct3[2] selects divide/remainder, funct3[1] selects remainder.
    assign w_div_zero = funct3[2] && (op_b == '0);
    assign w_div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                        (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign w_special  = w_div_zero || w_div_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = funct3[1] ? op_a : '1;
        else if (w_div_ovf)
            w_special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    assign w_accept = (r_state == ST_IDLE) && start && !flush;

    muldiv_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (w_accept && !w_special),
        .clear  (flush),
        .step   (r_state == ST_CALC),
        .is_div (r_funct3[2]),
        .a_mag  (w_mag_a),
        .b_mag  (w_mag_b),
        .hi     (w_hi),
        .lo     (w_lo),
        .last   (w_last)
    );

    // Sign fix-up on the unsigned magnitudes.
    assign w_prod = (r_sign_a ^ r_sign_b) ? -{w_hi, w_lo} : {w_hi, w_lo};
    assign w_quo  = (r_sign_a ^ r_sign_b) ? -w_lo : w_lo;
    assign w_rem  = r_sign_a ? -w_hi : w_hi;

    always_comb begin
        w_fix_res = w_prod[2*XLEN-1:XLEN];
        if (r_funct3[2])
            w_fix_res = r_funct3[1] ? w_rem : w_quo;
        else if (r_funct3 == F3_MUL)
            w_fix_res = w_prod[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_funct3 <= funct3;
                            r_rd     <= rd_in;
                            r_sign_a <= w_sign_a;
                            r_sign_b <= w_sign_b;
                            if (w_special) begin
                                r_result <= w_special_res;
                                r_rd_out <= rd_in;
                                r_done   <= 1'b1;
                                r_state  <= ST_DONE;
                            end else begin
                                r_state  <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        if (w_last)
                            r_state <= ST_FIX;
                    end
                    ST_FIX: begin
                        r_result <= w_fix_res;
                        r_rd_out <= r_rd;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // rst term keeps stall_req low during reset even if start is held high.
    assign stall_req = rst && (w_accept || (r_state == ST_CALC) || (r_state == ST_FIX));
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign result    = r_result;
    assign rd_out    = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit: directed vector table,
//            flush / async-reset sequences and randomized operations checked
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .flush     (flush),
        .stall_req (stall_req),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out),
        .busy      (busy)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from RV32M arithmetic rules.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub, q;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                q = sa / sb; return q[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        if (f3[2] && (b == 0 || ((f3 == 3'd4 || f3 == 3'd6) &&
                                 a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 34;
    endfunction

    // Issue one op with start held (as the stalled pipeline would) until done.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int  lat;
        bit  got;
        bit  stall_ok;
        @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
        #1;
        check({name, " stall_c0"}, {31'b0, stall_req}, 32'd1);
        got = 1'b0; stall_ok = 1'b1; lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c; got = 1'b1;
                break;
            end
            if (!stall_req) stall_ok = 1'b0;
        end
        if (!got) begin
            check({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, " result"}, result, exp);
            check({name, " rd_out"}, {27'b0, rd_out}, {27'b0, rd});
            check({name, " latency"}, lat, exp_lat);
            check({name, " stall_busy"}, {31'b0, stall_ok}, 32'd1);
            check({name, " stall_done"}, {31'b0, stall_req}, 32'd0);
            last_res = exp;
        end
        start = 1'b0;
        @(posedge clk); #1;
        check({name, " done_pulse"}, {31'b0, done}, 32'd0);
        check({name, " idle_after"}, {31'b0, busy}, 32'd0);
        check({name, " result_hold"}, result, last_res);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;
        int          flush_done_seen;

        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34};
        vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
        vecs[3]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       34};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        34};
        vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
        vecs[12] = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[13] = '{3'd7, 32'h0000BEEF, 32'd0,        32'h0000BEEF, 1};

        rst = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        rd_in = '0; flush = 1'b0; last_res = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   {31'b0, busy},      32'd0);
        check("reset stall",  {31'b0, stall_req}, 32'd0);
        check("reset done",   {31'b0, done},      32'd0);
        check("reset result", result,             32'd0);
        check("reset rd_out", {27'b0, rd_out},    32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                   5'(i + 3), vecs[i].exp, vecs[i].lat);

        // Flush during CALC: no done pulse, back to idle, result untouched.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd9;
        flush_done_seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (done) flush_done_seen++;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        check("flush busy",   {31'b0, busy},      32'd0);
        check("flush stall",  {31'b0, stall_req}, 32'd0);
        check("flush done",   {31'b0, done},      32'd0);
        check("flush result", result,             last_res);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) flush_done_seen++;
        end
        check("flush no_done", flush_done_seen, 32'd0);
        run_op("post_flush mulhu", 3'd3, 32'h12345678, 32'h9ABCDEF0, 5'd17,
               32'h0B00EA4E, 34);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op_a = 32'hDEADBEEF; op_b = 32'h1234; rd_in = 5'd21;
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst busy",   {31'b0, busy},      32'd0);
        check("arst stall",  {31'b0, stall_req}, 32'd0);
        check("arst done",   {31'b0, done},      32'd0);
        check("arst result", result,             32'd0);
        check("arst rd_out", {27'b0, rd_out},    32'd0);
        last_res = '0;
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        run_op("post_rst div", 3'd4, 32'hFFFFFF9C, 32'd7, 5'd30, 32'hFFFFFFF2, 34);

        for (int i = 0; i < 200; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            rrd = 5'($urandom_range(0, 31));
            run_op($sformatf("rnd%0d f3=%0d a=%h b=%h", i, rf3, ra, rb), rf3, ra, rb, rrd,
                   model(rf3, ra, rb), model_lat(rf3, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
